// File: rtl/ikascc_period_sched.sv
// ikascc_period_sched
// Per-channel period/step scheduler. One shared decrement/compare datapath is
// time-multiplexed across eight slots; slots 0..NCH-1 map to channels and the
// remaining slots are idle. The slot advances only on tick cycles
// (i_MCLK_PCEN_n low). Period writes can land on any cycle and optionally
// reload the count and clear the wave address of the written channel.
module ikascc_period_sched #(
    parameter int W   = 12,
    parameter int NCH = 5
) (
    input  logic               i_EMUCLK,
    input  logic               i_RST,
    input  logic               i_MCLK_PCEN_n,
    input  logic [NCH-1:0]     i_CH_EN,
    input  logic               i_PERIOD_WR,
    input  logic [2:0]         i_PERIOD_CH,
    input  logic [W-1:0]       i_PERIOD_D,
    input  logic               i_RELOAD_ON_WR,
    output logic [2:0]         o_SLOT,
    output logic [4:0]         o_CUR_ADDR,
    output logic [NCH-1:0]     o_STEP,
    output logic [5*NCH-1:0]   o_ADDR
);

    // Storage is sized for all eight slots so the 3-bit slot can index it
    // directly; entries at or above NCH are never written and stay zero.
    logic [W-1:0] period_q [8];
    logic [W-1:0] count_q  [8];
    logic [4:0]   addr_q   [8];
    logic [2:0]   slot_q;

    logic         tick;
    logic [7:0]   ch_en_ext;
    logic         slot_live;
    logic         wr_ok;
    logic         wr_hit;
    logic         ch_act;
    logic         cnt_zero;
    logic [W-1:0] cur_count;
    logic [4:0]   cur_addr;
    logic [W-1:0] count_nxt;
    logic [4:0]   addr_nxt;
    logic         step_now;
    logic [7:0]   step_vec;
    logic [4:0]   slot_addr;

    assign tick      = ~i_MCLK_PCEN_n;
    assign ch_en_ext = 8'(i_CH_EN);
    assign slot_live = ({1'b0, slot_q} < 4'(NCH));
    assign wr_ok     = i_PERIOD_WR && ({1'b0, i_PERIOD_CH} < 4'(NCH));
    assign wr_hit    = wr_ok && (i_PERIOD_CH == slot_q);

    // Shared datapath: evaluate the current slot's channel once per cycle.
    always_comb begin
        cur_count = count_q[slot_q];
        cur_addr  = addr_q[slot_q];
        cnt_zero  = (cur_count == '0);
        ch_act    = tick && slot_live && ch_en_ext[slot_q];
        count_nxt = cur_count - 1'b1;
        addr_nxt  = cur_addr;
        if (cnt_zero) begin
            count_nxt = period_q[slot_q];
            addr_nxt  = cur_addr + 5'd1;
        end
        // A write to the channel being serviced suppresses its step.
        step_now  = ch_act && cnt_zero && !wr_hit;
        step_vec  = 8'd1 << slot_q;
        slot_addr = cur_addr;
        if (!slot_live) begin
            slot_addr = 5'd0;
        end else if (wr_hit && i_RELOAD_ON_WR) begin
            slot_addr = 5'd0;
        end else if (ch_act) begin
            slot_addr = addr_nxt;
        end
    end

    // Channel state: tick update first, a same-cycle write overrides the fields it touches.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            for (int i = 0; i < 8; i++) begin
                period_q[i] <= '0;
                count_q[i]  <= '0;
                addr_q[i]   <= '0;
            end
        end else begin
            if (ch_act) begin
                count_q[slot_q] <= count_nxt;
                addr_q[slot_q]  <= addr_nxt;
            end
            if (wr_ok) begin
                period_q[i_PERIOD_CH] <= i_PERIOD_D;
                if (i_RELOAD_ON_WR) begin
                    count_q[i_PERIOD_CH] <= i_PERIOD_D;
                    addr_q[i_PERIOD_CH]  <= 5'd0;
                end
            end
        end
    end

    // Slot counter and per-tick status outputs; the step pulse lasts one cycle.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            slot_q     <= 3'd0;
            o_SLOT     <= 3'd0;
            o_CUR_ADDR <= 5'd0;
            o_STEP     <= '0;
        end else begin
            o_STEP <= step_now ? step_vec[NCH-1:0] : '0;
            if (tick) begin
                slot_q     <= slot_q + 3'd1;
                o_SLOT     <= slot_q;
                o_CUR_ADDR <= slot_addr;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_addr_out
        assign o_ADDR[5*c +: 5] = addr_q[c];
    end

endmodule

// File: tb/tb_ikascc_period_sched.sv
// Testbench for ikascc_period_sched: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the scheduling rules.
module tb_ikascc_period_sched;

    localparam int W   = 12;
    localparam int NCH = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             pcen_n;
    logic [NCH-1:0]   ch_en;
    logic             wr;
    logic [2:0]       wr_ch;
    logic [W-1:0]     wr_d;
    logic             rld;
    logic [2:0]       slot;
    logic [4:0]       cur_addr;
    logic [NCH-1:0]   step;
    logic [5*NCH-1:0] addr_bus;

    int n_vec = 0;
    int n_bad = 0;

    // Model state
    int          m_per  [NCH];
    int          m_cnt  [NCH];
    int          m_addr [NCH];
    int          m_s;
    logic [NCH-1:0] e_step;
    logic [2:0]  e_slot;
    logic [4:0]  e_cur;

    ikascc_period_sched #(.W(W), .NCH(NCH)) dut (
        .i_EMUCLK       (clk),
        .i_RST          (rst),
        .i_MCLK_PCEN_n  (pcen_n),
        .i_CH_EN        (ch_en),
        .i_PERIOD_WR    (wr),
        .i_PERIOD_CH    (wr_ch),
        .i_PERIOD_D     (wr_d),
        .i_RELOAD_ON_WR (rld),
        .o_SLOT         (slot),
        .o_CUR_ADDR     (cur_addr),
        .o_STEP         (step),
        .o_ADDR         (addr_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the rules of one clock edge to the model, using pre-edge state.
    task automatic model_edge();
        bit st;
        int s;
        st = 0;
        s  = m_s;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_per[c] = 0; m_cnt[c] = 0; m_addr[c] = 0;
            end
            m_s = 0; e_step = '0; e_slot = 3'd0; e_cur = 5'd0;
            return;
        end
        if (!pcen_n && s < NCH && ch_en[s]) begin
            if (m_cnt[s] == 0) begin
                m_cnt[s]  = m_per[s];
                m_addr[s] = (m_addr[s] + 1) % 32;
                st = !(wr && int'(wr_ch) == s);
            end else begin
                m_cnt[s] = m_cnt[s] - 1;
            end
        end
        if (wr && wr_ch < NCH) begin
            m_per[wr_ch] = int'(wr_d);
            if (rld) begin
                m_cnt[wr_ch]  = int'(wr_d);
                m_addr[wr_ch] = 0;
            end
        end
        e_step = '0;
        if (st) e_step[s] = 1'b1;
        if (!pcen_n) begin
            e_slot = 3'(s);
            e_cur  = (s < NCH) ? 5'(m_addr[s]) : 5'd0;
            m_s    = (s + 1) % 8;
        end
    endtask

    task automatic cyc(input bit t, input logic [NCH-1:0] en, input bit w,
                       input int ch, input int d, input bit r, input bit rs);
        pcen_n = !t; ch_en = en; wr = w; wr_ch = 3'(ch); wr_d = W'(d);
        rld = r; rst = rs;
        @(posedge clk);
        model_edge();
        #1;
        chk("step", 32'(step), 32'(e_step));
        chk("slot", 32'(slot), 32'(e_slot));
        chk("cur_addr", 32'(cur_addr), 32'(e_cur));
        for (int c = 0; c < NCH; c++)
            chk("addr", 32'(addr_bus[5*c +: 5]), 32'(m_addr[c]));
    endtask

    task automatic idle(input logic [NCH-1:0] en, input bit t);
        cyc(t, en, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int tk;
        int q_tick [$];
        int last, nst;

        for (int c = 0; c < NCH; c++) begin
            m_per[c] = 0; m_cnt[c] = 0; m_addr[c] = 0;
        end
        m_s = 0; e_step = '0; e_slot = 0; e_cur = 0;

        // Reset state
        cyc(1, '1, 1, 1, 7, 1, 1);
        cyc(0, '0, 0, 0, 0, 0, 1);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_addr", 32'(addr_bus), 32'd0);

        // Channel 0, period 0, tick every cycle: steps at ticks 1, 9, 17
        for (int k = 1; k <= 17; k++) begin
            idle(5'b00001, 1);
            if (step[0]) q_tick.push_back(k);
        end
        chk("c0_nstep", 32'(q_tick.size()), 32'd3);
        if (q_tick.size() == 3) begin
            chk("c0_t1", 32'(q_tick[0]), 32'd1);
            chk("c0_t2", 32'(q_tick[1]), 32'd9);
            chk("c0_t3", 32'(q_tick[2]), 32'd17);
        end
        chk("c0_addr", 32'(addr_bus[4:0]), 32'd3);

        // Channel 2 period 3 with reload: one step per 32 ticks, address wraps
        cyc(0, 5'b00100, 1, 2, 3, 1, 0);
        last = -1; nst = 0; tk = 0;
        while (nst < 32 && tk < 1200) begin
            idle(5'b00100, 1);
            tk++;
            if (step[2]) begin
                if (last >= 0) chk("c2_interval", 32'(tk - last), 32'd32);
                last = tk;
                nst++;
            end
        end
        chk("c2_nstep", 32'(nst), 32'd32);
        chk("c2_wrap", 32'(addr_bus[14:10]), 32'd0);

        // Tick every third cycle
        for (int k = 0; k < 60; k++) idle(5'b10011, (k % 3) == 0);

        // Write-reload on ch1 colliding with its count==0 tick
        cyc(0, 5'b00010, 1, 1, 0, 1, 0);
        tk = 0;
        while (m_s != 1 && tk < 20) begin idle(5'b00010, 1); tk++; end
        cyc(1, 5'b00010, 1, 1, 9, 1, 0);
        chk("c1_coll_step", 32'(step[1]), 32'd0);
        chk("c1_coll_addr", 32'(addr_bus[9:5]), 32'd0);
        for (int k = 0; k < 90; k++) idle(5'b00010, 1);

        // Out-of-range write, then reset mid-run
        cyc(1, '1, 1, 6, 5, 1, 0);
        for (int k = 0; k < 30; k++) idle('1, 1);
        cyc(1, '1, 1, 0, 2, 1, 1);
        chk("mid_rst_slot", 32'(slot), 32'd0);
        chk("mid_rst_step", 32'(step), 32'd0);
        idle('1, 1);

        // Disable ch0 for 20 ticks, then re-enable
        cyc(0, 5'b00001, 1, 0, 2, 1, 0);
        for (int k = 0; k < 13; k++) idle(5'b00001, 1);
        for (int k = 0; k < 20; k++) idle(5'b00000, 1);
        for (int k = 0; k < 60; k++) idle(5'b00001, 1);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 1) == 1,
                NCH'($urandom),
                $urandom_range(0, 5) == 0,
                int'($urandom_range(0, 7)),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
